// File: rtl/count_sequencer_pkg.sv
// count_sequencer_pkg
//   Shared definitions for the count sequencer slice: the FSM state
//   enumeration and the default widths of the count and repetition paths.
package count_sequencer_pkg;

  localparam int CNT_W_DEFAULT = 7;
  localparam int REP_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

endpackage : count_sequencer_pkg

// File: rtl/count_sequencer_sat.sv
// sat_counter
//   Saturating up-counter. It counts inc pulses, sticks at all-ones and
//   returns to zero on clear (clear has priority over inc).
// Ports:
//   clk    in   clock, rising edge
//   reset  in   synchronous active-high reset
//   clear  in   synchronous clear to zero
//   inc    in   increment request
//   value  out  W-bit counter value
module sat_counter
  import count_sequencer_pkg::*;
#(
  parameter int W = REP_W_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] value
);

  localparam logic [W-1:0] ONE = 1;

  logic [W-1:0] value_q;
  logic [W-1:0] value_d;

  // Next value: clear wins, otherwise step unless already at the ceiling.
  always_comb begin
    value_d = value_q;
    if (clear) begin
      value_d = '0;
    end else if (inc && (value_q != '1)) begin
      value_d = value_q + ONE;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule : sat_counter

// File: rtl/count_sequencer.sv
// count_sequencer
//   Drives a free-running count 1..P,0 to downstream comparators, either for
//   N repetitions (one-shot) or until aborted (continuous), with pause, abort
//   and a saturating tally of comparator match pulses. All outputs are flops.
// Ports:
//   counter_clk in   clock, rising edge
//   reset       in   synchronous active-high reset
//   start       in   one-cycle request to begin a sequence
//   abort       in   one-cycle request to stop immediately (beats start)
//   pause       in   level, holds the count while high
//   continuous  in   1 = repeat until abort, 0 = n_cycles repetitions
//   period      in   terminal count P (sampled at start, 0 is rejected)
//   n_cycles    in   repetitions N (sampled at start, 0 means 1)
//   comp        in   match pulse from the comparator
//   count       out  counter value
//   count_en    out  comparator enable, high in RUN only
//   wrap        out  pulse in the cycle count returns to 0
//   busy        out  high in RUN or PAUSE
//   done        out  completion pulse of a one-shot sequence
//   hit_cnt     out  comp pulses seen in the current or last sequence
//   err         out  pulse on a start with period == 0
module count_sequencer
  import count_sequencer_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT,
  parameter int REP_W = REP_W_DEFAULT
) (
  input  logic             counter_clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             pause,
  input  logic             continuous,
  input  logic [CNT_W-1:0] period,
  input  logic [REP_W-1:0] n_cycles,
  input  logic             comp,
  output logic [CNT_W-1:0] count,
  output logic             count_en,
  output logic             wrap,
  output logic             busy,
  output logic             done,
  output logic [REP_W-1:0] hit_cnt,
  output logic             err
);

  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [REP_W-1:0] REP_ONE = 1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] p_q, p_d;
  logic [REP_W-1:0] n_q, n_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic             cont_q, cont_d;
  logic             wrap_q, wrap_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic             count_en_q, count_en_d;
  logic             hit_clear;
  logic [REP_W-1:0] n_eff;
  logic             last_wrap;

  // A one-shot request for zero repetitions still runs one period.
  assign n_eff = (n_q == '0) ? REP_ONE : n_q;

  // count is only 0 inside RUN during a wrap cycle, so this flags the
  // final wrap cycle of a one-shot sequence.
  assign last_wrap = (count_q == '0) && !cont_q && (rep_q == n_eff);

  // Next-state and next-output logic. Finishing a one-shot takes priority
  // over pause so the last wrap cycle is always the last RUN cycle; abort
  // overrides everything, including a simultaneous start.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    p_d       = p_q;
    n_d       = n_q;
    rep_d     = rep_q;
    cont_d    = cont_q;
    wrap_d    = 1'b0;
    err_d     = 1'b0;
    hit_clear = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (period != '0) begin
            p_d       = period;
            n_d       = n_cycles;
            cont_d    = continuous;
            rep_d     = '0;
            hit_clear = 1'b1;
            count_d   = CNT_ONE;
            state_d   = S_RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      S_RUN, S_PAUSE: begin
        if ((state_q == S_RUN) && last_wrap) begin
          state_d = S_DONE;
          count_d = '0;
        end else if (pause) begin
          state_d = S_PAUSE;
        end else begin
          state_d = S_RUN;
          if (count_q == p_q) begin
            count_d = '0;
            wrap_d  = 1'b1;
            rep_d   = rep_q + REP_ONE;
          end else begin
            count_d = count_q + CNT_ONE;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        count_d = '0;
      end

      default: begin
        state_d = S_IDLE;
        count_d = '0;
      end
    endcase

    if (abort) begin
      state_d   = S_IDLE;
      count_d   = '0;
      p_d       = p_q;
      n_d       = n_q;
      cont_d    = cont_q;
      rep_d     = rep_q;
      wrap_d    = 1'b0;
      err_d     = 1'b0;
      hit_clear = 1'b0;
    end

    done_d     = (state_d == S_DONE);
    busy_d     = (state_d == S_RUN) || (state_d == S_PAUSE);
    count_en_d = (state_d == S_RUN);
  end

  // State and output registers.
  always_ff @(posedge counter_clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      p_q        <= '0;
      n_q        <= '0;
      rep_q      <= '0;
      cont_q     <= 1'b0;
      wrap_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      count_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      p_q        <= p_d;
      n_q        <= n_d;
      rep_q      <= rep_d;
      cont_q     <= cont_d;
      wrap_q     <= wrap_d;
      done_q     <= done_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      count_en_q <= count_en_d;
    end
  end

  // Match tally: counts comp while busy, held in IDLE until the next
  // accepted start clears it.
  sat_counter #(
    .W (REP_W)
  ) u_hit_cnt (
    .clk   (counter_clk),
    .reset (reset),
    .clear (hit_clear),
    .inc   (comp && busy_q),
    .value (hit_cnt)
  );

  assign count    = count_q;
  assign count_en = count_en_q;
  assign wrap     = wrap_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule : count_sequencer

// File: tb/tb_count_sequencer.sv
// tb_count_sequencer
//   Self-checking bench for count_sequencer. Each cycle the expected outputs
//   are pushed to a scoreboard when the inputs are driven and popped and
//   compared after the clock edge that produces them.
module tb_count_sequencer;

   localparam int CNT_W = 7;
   localparam int REP_W = 8;

   logic             counterClk;
   logic             reset;
   logic             start;
   logic             abort;
   logic             pause;
   logic             continuousMode;
   logic [CNT_W-1:0] period;
   logic [REP_W-1:0] nCycles;
   logic             comp;
   logic [CNT_W-1:0] count;
   logic             countEn;
   logic             wrap;
   logic             busy;
   logic             done;
   logic [REP_W-1:0] hitCnt;
   logic             err;

   typedef struct {
      string tag;
      int    count;
      bit    countEn;
      bit    wrap;
      bit    busy;
      bit    done;
      bit    err;
      int    hitCnt;
   } expT;

   expT scoreboard[$];
   int  assertCount = 0;
   int  failCount   = 0;

   count_sequencer #(
      .CNT_W (CNT_W),
      .REP_W (REP_W)
   ) dut (
      .counter_clk (counterClk),
      .reset       (reset),
      .start       (start),
      .abort       (abort),
      .pause       (pause),
      .continuous  (continuousMode),
      .period      (period),
      .n_cycles    (nCycles),
      .comp        (comp),
      .count       (count),
      .count_en    (countEn),
      .wrap        (wrap),
      .busy        (busy),
      .done        (done),
      .hit_cnt     (hitCnt),
      .err         (err)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial counterClk = 1'b0;
   always #5 counterClk = ~counterClk;

   // Safety net so the run always ends even if the stimulus stalls.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Single comparison point: counts every check, reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Called at a falling edge with the inputs already set: records what the
   // DUT must show after the next rising edge, lets that edge happen, then
   // pops the record and compares every output.
   task automatic applyStimulus(input string tag, input int expCount,
                                input bit expEn, input bit expWrap,
                                input bit expBusy, input bit expDone,
                                input bit expErr, input int expHit);
      expT e;
      e.tag     = tag;
      e.count   = expCount;
      e.countEn = expEn;
      e.wrap    = expWrap;
      e.busy    = expBusy;
      e.done    = expDone;
      e.err     = expErr;
      e.hitCnt  = expHit;
      scoreboard.push_back(e);
      @(negedge counterClk);
      e = scoreboard.pop_front();
      checkOutput({e.tag, ".count"},    32'(count),   32'(e.count));
      checkOutput({e.tag, ".count_en"}, 32'(countEn), 32'(e.countEn));
      checkOutput({e.tag, ".wrap"},     32'(wrap),    32'(e.wrap));
      checkOutput({e.tag, ".busy"},     32'(busy),    32'(e.busy));
      checkOutput({e.tag, ".done"},     32'(done),    32'(e.done));
      checkOutput({e.tag, ".err"},      32'(err),     32'(e.err));
      checkOutput({e.tag, ".hit_cnt"},  32'(hitCnt),  32'(e.hitCnt));
   endtask

   // Directed scenarios, each written as the cycle-by-cycle expectation.
   initial begin
      int c;
      int h;

      reset          = 1'b1;
      start          = 1'b0;
      abort          = 1'b0;
      pause          = 1'b0;
      continuousMode = 1'b0;
      period         = '0;
      nCycles        = '0;
      comp           = 1'b0;
      @(negedge counterClk);

      // Reset state, and reset beating a simultaneous start/pause.
      applyStimulus("reset", 0, 0, 0, 0, 0, 0, 0);
      start  = 1'b1;
      pause  = 1'b1;
      period = 7'd3;
      applyStimulus("resetOverStart", 0, 0, 0, 0, 0, 0, 0);
      reset = 1'b0;
      start = 1'b0;
      pause = 1'b0;
      applyStimulus("idleAfterReset", 0, 0, 0, 0, 0, 0, 0);

      // One-shot P=3, N=2 with a comp pulse and an ignored start mid-run.
      period  = 7'd3;
      nCycles = 8'd2;
      start   = 1'b1;
      applyStimulus("oneShot.c1", 1, 1, 0, 1, 0, 0, 0);
      start = 1'b0;
      comp  = 1'b1;
      applyStimulus("oneShot.c2", 2, 1, 0, 1, 0, 0, 1);
      comp = 1'b0;
      applyStimulus("oneShot.c3", 3, 1, 0, 1, 0, 0, 1);
      applyStimulus("oneShot.c4", 0, 1, 1, 1, 0, 0, 1);
      applyStimulus("oneShot.c5", 1, 1, 0, 1, 0, 0, 1);
      start  = 1'b1;
      period = 7'd1;
      applyStimulus("oneShot.busyStart", 2, 1, 0, 1, 0, 0, 1);
      start  = 1'b0;
      period = 7'd3;
      applyStimulus("oneShot.c7", 3, 1, 0, 1, 0, 0, 1);
      applyStimulus("oneShot.c8", 0, 1, 1, 1, 0, 0, 1);
      applyStimulus("oneShot.done", 0, 0, 0, 0, 1, 0, 1);
      applyStimulus("oneShot.idle", 0, 0, 0, 0, 0, 0, 1);

      // Rejected start: err for one cycle, hit_cnt untouched.
      period = 7'd0;
      start  = 1'b1;
      applyStimulus("reject.err", 0, 0, 0, 0, 0, 1, 1);
      start  = 1'b0;
      period = 7'd5;
      applyStimulus("reject.after", 0, 0, 0, 0, 0, 0, 1);

      // Pause at count 2 for three cycles; inputs changed while paused.
      nCycles = 8'd1;
      start   = 1'b1;
      applyStimulus("pause.c1", 1, 1, 0, 1, 0, 0, 0);
      start = 1'b0;
      applyStimulus("pause.c2", 2, 1, 0, 1, 0, 0, 0);
      pause          = 1'b1;
      period         = 7'd1;
      nCycles        = 8'd7;
      continuousMode = 1'b1;
      for (int i = 0; i < 3; i++) begin
         applyStimulus($sformatf("pause.hold%0d", i), 2, 0, 0, 1, 0, 0, 0);
      end
      pause = 1'b0;
      applyStimulus("pause.resume", 3, 1, 0, 1, 0, 0, 0);
      applyStimulus("pause.c4", 4, 1, 0, 1, 0, 0, 0);
      applyStimulus("pause.c5", 5, 1, 0, 1, 0, 0, 0);
      applyStimulus("pause.wrap", 0, 1, 1, 1, 0, 0, 0);
      applyStimulus("pause.done", 0, 0, 0, 0, 1, 0, 0);
      applyStimulus("pause.idle", 0, 0, 0, 0, 0, 0, 0);

      // Abort and start together at count 4.
      period         = 7'd6;
      nCycles        = 8'd1;
      continuousMode = 1'b0;
      start          = 1'b1;
      applyStimulus("abort.c1", 1, 1, 0, 1, 0, 0, 0);
      start = 1'b0;
      applyStimulus("abort.c2", 2, 1, 0, 1, 0, 0, 0);
      applyStimulus("abort.c3", 3, 1, 0, 1, 0, 0, 0);
      applyStimulus("abort.c4", 4, 1, 0, 1, 0, 0, 0);
      abort = 1'b1;
      start = 1'b1;
      applyStimulus("abort.idle", 0, 0, 0, 0, 0, 0, 0);
      abort = 1'b0;
      start = 1'b0;
      applyStimulus("abort.noRestart", 0, 0, 0, 0, 0, 0, 0);

      // Continuous mode with 300 comp pulses: hit_cnt saturates at 255.
      period         = 7'd3;
      nCycles        = 8'd1;
      continuousMode = 1'b1;
      start          = 1'b1;
      applyStimulus("cont.start", 1, 1, 0, 1, 0, 0, 0);
      start = 1'b0;
      comp  = 1'b1;
      c = 1;
      h = 0;
      for (int i = 1; i <= 300; i++) begin
         c = (c == 3) ? 0 : c + 1;
         h = (h < 255) ? h + 1 : 255;
         applyStimulus($sformatf("cont.cyc%0d", i), c, 1, (c == 0), 1, 0, 0, h);
      end
      comp  = 1'b0;
      abort = 1'b1;
      applyStimulus("cont.abort", 0, 0, 0, 0, 0, 0, 255);
      abort = 1'b0;
      applyStimulus("cont.hold", 0, 0, 0, 0, 0, 0, 255);

      // Next accepted start clears hits; reset mid-sequence at count 2.
      period         = 7'd2;
      nCycles        = 8'd0;
      continuousMode = 1'b0;
      start          = 1'b1;
      applyStimulus("midReset.c1", 1, 1, 0, 1, 0, 0, 0);
      start = 1'b0;
      comp  = 1'b1;
      applyStimulus("midReset.c2", 2, 1, 0, 1, 0, 0, 1);
      comp  = 1'b0;
      reset = 1'b1;
      applyStimulus("midReset.reset", 0, 0, 0, 0, 0, 0, 0);
      reset = 1'b0;

      // N = 0 one-shot runs exactly one period.
      start = 1'b1;
      applyStimulus("nZero.c1", 1, 1, 0, 1, 0, 0, 0);
      start = 1'b0;
      applyStimulus("nZero.c2", 2, 1, 0, 1, 0, 0, 0);
      applyStimulus("nZero.wrap", 0, 1, 1, 1, 0, 0, 0);
      applyStimulus("nZero.done", 0, 0, 0, 0, 1, 0, 0);
      applyStimulus("nZero.idle", 0, 0, 0, 0, 0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               assertCount, failCount);
      $finish;
   end

endmodule : tb_count_sequencer

// File: doc/count_sequencer.md
COUNT_SEQUENCER -- requirements
Module: count_sequencer

Interface
REQ-001 Parameter CNT_W, default 7: width of period and count.
REQ-002 Parameter REP_W, default 8: width of n_cycles and hit_cnt.
REQ-003 counter_clk  in  1  sole clock; all logic samples on the rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 start  in  1  one-cycle request to begin a sequence.
REQ-006 abort  in  1  one-cycle request to stop immediately.
REQ-007 pause  in  1  level; high holds the count.
REQ-008 continuous  in  1  1 = repeat until abort; 0 = one-shot of n_cycles periods.
REQ-009 period  in  CNT_W  terminal count P; sampled at start.
REQ-010 n_cycles  in  REP_W  repetitions N; sampled at start.
REQ-011 comp  in  1  match pulse returned by the downstream comparator.
REQ-012 count  out  CNT_W  counter value driven to the comparators.
REQ-013 count_en  out  1  comparator enable.
REQ-014 wrap  out  1  one-cycle pulse when count returns to 0.
REQ-015 busy  out  1  high in RUN or PAUSE.
REQ-016 done  out  1  one-cycle completion pulse.
REQ-017 hit_cnt  out  REP_W  number of comp pulses seen in the current or last sequence.
REQ-018 err  out  1  one-cycle pulse on a rejected start.

Function
REQ-019 The FSM SHALL have states IDLE, RUN, PAUSE and DONE; all outputs are registered.
REQ-020 In IDLE, start with period != 0 SHALL latch P and N, clear hit_cnt and the repetition counter, and enter RUN with count = 1 in the next cycle.
REQ-021 In IDLE, start with period == 0 SHALL pulse err for one cycle and remain in IDLE.
REQ-022 In RUN, count SHALL increment by 1 each cycle; when count == P, the next value is 0 and wrap is 1 in that cycle.
REQ-023 Each repetition lasts P+1 cycles and visits 1..P,0, so every value, including 0 and P, is produced as a change of count.
REQ-024 The repetition counter SHALL increment on each wrap; in one-shot mode, N == 0 is treated as N = 1.
REQ-025 In one-shot mode, the N-th wrap cycle SHALL be the last RUN cycle; the next cycle is DONE with done = 1, busy = 0 and count = 0, followed by IDLE.
REQ-026 In continuous mode, n_cycles SHALL be ignored; the repetition counter wraps silently and RUN continues until abort.
REQ-027 In RUN, pause high at a clock edge SHALL enter PAUSE; count is frozen and count_en = 0.
REQ-028 In PAUSE, pause low at a clock edge SHALL return to RUN, and count increments in the first RUN cycle.
REQ-029 abort in any state SHALL go to IDLE next cycle with count = 0; done and wrap are not asserted.
REQ-030 If start and abort are asserted together, abort SHALL win.
REQ-031 start while busy SHALL be ignored; err is not asserted.
REQ-032 count_en SHALL be 1 in RUN only.
REQ-033 hit_cnt SHALL increment on comp while busy, saturate at 2^REP_W-1, and hold its value in IDLE until the next accepted start.
REQ-034 In PAUSE, changes to period, n_cycles or continuous SHALL have no effect; the values latched at start apply.

Reset
REQ-035 Reset SHALL force state = IDLE, count = 0, count_en = 0, wrap = 0, busy = 0, done = 0, err = 0, hit_cnt = 0 and repetition counter = 0.
REQ-036 Reset SHALL override start, abort and pause in the same cycle.
REQ-037 Reset asserted mid-sequence SHALL return the block to IDLE next cycle with no done pulse.

Structure
REQ-038 A shared package SHALL hold the state enumeration and the CNT_W/REP_W defaults.
REQ-039 The saturating hit counter SHALL be a sub-module, sat_counter (clear, inc, width parameter).

Verification
REQ-040 One-shot sequence: P = 3, N = 2, start at cycle 0 -> count 1,2,3,0,1,2,3,0 in cycles 1-8, wrap in cycles 4 and 8, done in cycle 9, then IDLE.
REQ-041 Pause: P = 5, pause high for 3 cycles while count = 2 -> count stays 2 for 3 cycles with count_en = 0, then resumes at 3.
REQ-042 Abort and start together: during RUN at count = 4, abort and start asserted together -> IDLE next cycle, count = 0, no done, no restart.
REQ-043 Rejected start: period = 0 with start -> err for one cycle, busy stays 0.
REQ-044 Saturating hits: REP_W = 8, continuous mode, 300 comp pulses -> hit_cnt = 255; the next accepted start clears it to 0.
REQ-045 Reset mid-sequence: reset at count = 2 -> all outputs are at reset values in the next cycle, and N = 0 one-shot then runs exactly one period.
